eru_err_monitor: RTL and testbench

ERU_ERR_MONITOR -- requirements
Module: eru_err_monitor

---
 rtl/eru_err_monitor.sv | 130 +++++++++++++
 tb/tb_eru_err_monitor.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eru_err_monitor.sv
// eru_err_monitor: windowed error-distance statistics for an approximate 16-bit adder.
// Define ERU_ERR_HIST_EN to add the hist0..hist3 error-distance histogram outputs.
module eru_err_monitor #(
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [15:0]      win_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      a,
   input  logic [15:0]      b,
   input  logic [16:0]      approx_sum,
   output logic             busy,
   output logic             done,
   output logic [15:0]      err_cnt,
   output logic [16:0]      max_ed,
   output logic [ACC_W-1:0] sum_ed,
`ifdef ERU_ERR_HIST_EN
   output logic [15:0]      hist0,
   output logic [15:0]      hist1,
   output logic [15:0]      hist2,
   output logic [15:0]      hist3,
`endif
   output logic             sat
);
   localparam int AW1 = ACC_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t           state_q, state_d;
   logic [15:0]      win_q, win_d, cnt_q, cnt_d, err_q, err_d;
   logic [16:0]      ed_q, ed_d, max_q, max_d, exact, ed_new;
   logic             edv_q, edv_d, sat_q, sat_d, accept, clr;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [AW1-1:0]   sum_ext;

   assign in_ready = (state_q == RUN);
   assign busy     = (state_q == RUN) || (state_q == FLUSH);
   assign done     = (state_q == DONE);
   assign err_cnt  = err_q;
   assign max_ed   = max_q;
   assign sum_ed   = sum_q;
   assign sat      = sat_q;

   always_comb begin
      exact   = 17'(a) + 17'(b);
      ed_new  = (exact >= approx_sum) ? exact - approx_sum : approx_sum - exact;
      accept  = in_valid && (state_q == RUN);
      clr     = start && (state_q == IDLE || state_q == DONE);
      sum_ext = {1'b0, sum_q} + {{(AW1-17){1'b0}}, ed_q};
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = accept ? cnt_q + 16'd1 : cnt_q;
      ed_d    = accept ? ed_new : ed_q;
      edv_d   = accept;
      // ed_q/edv_q hold the previous accept; it is folded in one edge later
      err_d   = edv_q ? err_q + 16'(ed_q != '0) : err_q;
      max_d   = (edv_q && ed_q > max_q) ? ed_q : max_q;
      sum_d   = !edv_q ? sum_q : (sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0]);
      sat_d   = sat_q | (edv_q & sum_ext[ACC_W]);
      case (state_q)
         RUN:     if (accept && cnt_d == win_q) state_d = FLUSH;
         FLUSH:   state_d = DONE;
         default: ;
      endcase
      if (clr) begin
         state_d = (win_len == '0) ? DONE : RUN;
         win_d   = win_len;
         cnt_d   = '0;
         ed_d    = '0;
         edv_d   = 1'b0;
         err_d   = '0;
         max_d   = '0;
         sum_d   = '0;
         sat_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         win_q   <= '0;
         cnt_q   <= '0;
         ed_q    <= '0;
         edv_q   <= 1'b0;
         err_q   <= '0;
         max_q   <= '0;
         sum_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         ed_q    <= ed_d;
         edv_q   <= edv_d;
         err_q   <= err_d;
         max_q   <= max_d;
         sum_q   <= sum_d;
         sat_q   <= sat_d;
      end
   end

`ifdef ERU_ERR_HIST_EN
   logic [15:0] hist_q [4];
   logic [15:0] hist_d [4];
   logic [1:0]  bin;

   always_comb begin
      bin = (ed_q == '0) ? 2'd0 : (ed_q < 17'd256) ? 2'd1 : (ed_q < 17'd4096) ? 2'd2 : 2'd3;
      for (int i = 0; i < 4; i++)
         hist_d[i] = clr ? '0 : hist_q[i] + 16'(edv_q && bin == 2'(i) && hist_q[i] != 16'hFFFF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
      end
   end

   assign hist0 = hist_q[0];
   assign hist1 = hist_q[1];
   assign hist2 = hist_q[2];
   assign hist3 = hist_q[3];
`endif

endmodule

// File: tb/tb_eru_err_monitor.sv
// tb_eru_err_monitor: randomized and directed windows checked by a scoreboard against a
// behavioural statistics model; hist outputs are checked when ERU_ERR_HIST_EN is defined.
module tb_eru_err_monitor;
   localparam int ACC_W = 17;
   localparam longint MAXS = (longint'(1) << ACC_W) - 1;

   typedef struct {
      int     err;
      int     mx;
      longint sum;
      int     sat;
      int     h0, h1, h2, h3;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [15:0]      win_len = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      a = '0, b = '0;
   logic [16:0]      approx_sum = '0;
   logic             busy, done, sat;
   logic [15:0]      err_cnt;
   logic [16:0]      max_ed;
   logic [ACC_W-1:0] sum_ed;
`ifdef ERU_ERR_HIST_EN
   logic [15:0]      hist0, hist1, hist2, hist3;
`endif

   eru_err_monitor #(.ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx_sum(approx_sum),
      .busy(busy), .done(done), .err_cnt(err_cnt), .max_ed(max_ed), .sum_ed(sum_ed),
`ifdef ERU_ERR_HIST_EN
      .hist0(hist0), .hist1(hist1), .hist2(hist2), .hist3(hist3),
`endif
      .sat(sat)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_tot = 0;
   exp_t exp_q[$];
   exp_t last_e;
   logic [15:0] qa[$], qb[$];
   logic [16:0] qx[$];

   task automatic chk(string name, longint got, longint expv);
      n_tot++;
      if (got == expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_samples;
      qa.delete();
      qb.delete();
      qx.delete();
   endtask

   task automatic add(logic [15:0] sa, logic [15:0] sb, logic [16:0] sx);
      qa.push_back(sa);
      qb.push_back(sb);
      qx.push_back(sx);
   endtask

   function automatic exp_t model(int n);
      exp_t e;
      longint tot = 0;
      e = '{default: 0};
      for (int i = 0; i < n; i++) begin
         int d = int'(qa[i]) + int'(qb[i]) - int'(qx[i]);
         if (d < 0) d = -d;
         if (d != 0) e.err++;
         if (d > e.mx) e.mx = d;
         tot += d;
         if (d == 0) e.h0++;
         else if (d < 256) e.h1++;
         else if (d < 4096) e.h2++;
         else e.h3++;
      end
      e.sat = (tot > MAXS) ? 1 : 0;
      e.sum = (tot > MAXS) ? MAXS : tot;
      return e;
   endfunction

   task automatic gen(int n);
      clr_samples();
      for (int i = 0; i < n; i++) begin
         int sa = int'($urandom_range(0, 16'hFFFF));
         int sb = int'($urandom_range(0, 16'hFFFF));
         int ex = sa + sb;
         int x;
         case ($urandom_range(0, 3))
            0:       x = ex;
            1:       x = (ex ^ int'($urandom_range(0, 255))) & 'h1FFFF;
            2:       x = int'($urandom_range(0, 'h1FFFF));
            default: x = (ex ^ (1 << $urandom_range(0, 16))) & 'h1FFFF;
         endcase
         add(16'(sa), 16'(sb), 17'(x));
      end
   endtask

   // Stats are compared by the monitor; the driver checks handshake, timing and hold.
   task automatic run_window(int len, bit gaps, bit poke);
      exp_t e;
      int guard;
      e = model(len);
      exp_q.push_back(e);
      last_e = e;
      start = 1'b1;
      win_len = 16'(len);
      tick();
      start = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (gaps && i > 0) begin
            in_valid = 1'b0;
            tick();
         end
         a = qa[i];
         b = qb[i];
         approx_sum = qx[i];
         in_valid = 1'b1;
         if (poke && i == 1) begin
            start = 1'b1;
            win_len = 16'd1;
         end
         guard = 0;
         while (!in_ready && guard < 8) begin
            tick();
            guard++;
         end
         if (!in_ready) chk("in_ready_timeout", in_ready, 1);
         tick();
         start = 1'b0;
      end
      if (len > 0) begin
         chk("flush_in_ready", in_ready, 0);
         chk("flush_busy", busy, 1);
      end
      guard = 0;
      while (!done && guard < 10) begin
         tick();
         guard++;
      end
      chk("done_latency", guard, (len > 0) ? 1 : 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("done_in_ready", in_ready, 0);
      end
      chk("hold_err_cnt", err_cnt, last_e.err);
      chk("hold_sum_ed", sum_ed, last_e.sum);
      in_valid = 1'b0;
   endtask

   initial begin : monitor
      bit pd = 1'b0, ps = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (done && (!pd || ps)) begin
            if (exp_q.size() == 0) chk("sb_unexpected_done", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               chk("err_cnt", err_cnt, e.err);
               chk("max_ed", max_ed, e.mx);
               chk("sum_ed", sum_ed, e.sum);
               chk("sat", sat, e.sat);
`ifdef ERU_ERR_HIST_EN
               chk("hist0", hist0, e.h0);
               chk("hist1", hist1, e.h1);
               chk("hist2", hist2, e.h2);
               chk("hist3", hist3, e.h3);
`endif
            end
         end
         pd = done;
         ps = start;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_sum_ed", sum_ed, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b1;
      tick();
      tick();
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      in_valid = 1'b0;

      clr_samples();
      add(16'h00FF, 16'h0001, 17'h00100);
      add(16'h00FF, 16'h0001, 17'h000FF);
      add(16'h8000, 16'h8000, 17'h00000);
      add(16'h1234, 16'h0001, 17'h01235);
      run_window(4, 1'b0, 1'b0);

      clr_samples();
      add(16'h0010, 16'h0020, 17'h00031);
      add(16'hFFFF, 16'hFFFF, 17'h1FFFE);
      add(16'h0100, 16'h0000, 17'h00000);
      run_window(3, 1'b1, 1'b0);

      clr_samples();
      run_window(0, 1'b0, 1'b0);

      clr_samples();
      add(16'h0000, 16'h0000, 17'h1FFFF);
      add(16'h0001, 16'h0000, 17'h00000);
      run_window(2, 1'b0, 1'b1);

      clr_samples();
      add(16'h1000, 16'h0000, 17'h01000);
      add(16'h1000, 16'h0000, 17'h01005);
      add(16'h1000, 16'h0000, 17'h0112C);
      add(16'h1000, 16'h0000, 17'h02388);
      run_window(4, 1'b0, 1'b0);

      gen(8);
      start = 1'b1;
      win_len = 16'd8;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = qa[i];
         b = qb[i];
         approx_sum = qx[i];
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("amid_in_ready", in_ready, 0);
      chk("amid_busy", busy, 0);
      chk("amid_done", done, 0);
      chk("amid_err_cnt", err_cnt, 0);
      chk("amid_max_ed", max_ed, 0);
      chk("amid_sum_ed", sum_ed, 0);
      chk("amid_sat", sat, 0);
      tick();
      rst_n = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("post_rst_in_ready", in_ready, 0);
         chk("post_rst_busy", busy, 0);
      end
      in_valid = 1'b0;

      for (int w = 0; w < 20; w++) begin
         int len = int'($urandom_range(1, 12));
         gen(len);
         run_window(len, 1'($urandom_range(0, 1)), 1'(len > 1 && $urandom_range(0, 1) == 1));
      end

      tick();
      tick();
      chk("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
